// File: rtl/binary_game_pkg.sv
// Shared types and constants for the binary complement game engine.
package binary_game_pkg;

    typedef enum logic [2:0] {
        LOGIN, LOCKOUT, IDLE, GEN, WAIT, CHECK, NEXT, DONE
    } game_state_t;

    localparam int SCORE_MAX = 15;

    // Galois feedback masks giving a maximal-length sequence for each width
    function automatic logic [7:0] lfsr_taps(input int w);
        case (w)
            3:       return 8'h06;
            4:       return 8'h0C;
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            default: return 8'hB8;
        endcase
    endfunction

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 5'(SCORE_MAX)) ? 4'(SCORE_MAX) : s[3:0];
    endfunction

endpackage

// File: rtl/binary_game_engine_if.sv
// Button/switch inputs and display-facing outputs of the game engine.
// The streak output exists only when STREAK_BONUS_EN is defined.
interface binary_game_engine_if #(parameter int W = 4);
    logic [W-1:0] pw_in;
    logic         pw_btn;
    logic         start_btn;
    logic [W-1:0] ans_in;
    logic         ans_btn;
    logic         logged_in;
    logic         locked;
    logic [W-1:0] rng_val;
    logic [W-1:0] ans_val;
    logic [W:0]   sum_val;
    logic         match;
    logic         miss;
    logic [3:0]   score;
    logic [3:0]   round_num;
    logic [6:0]   time_left;
    logic         game_over;
`ifdef STREAK_BONUS_EN
    logic [1:0]   streak;
`endif

    modport master (
        output pw_in, pw_btn, start_btn, ans_in, ans_btn,
        input  logged_in, locked, rng_val, ans_val, sum_val, match, miss,
        input  score, round_num, time_left, game_over
`ifdef STREAK_BONUS_EN
        , input streak
`endif
    );

    modport slave (
        input  pw_in, pw_btn, start_btn, ans_in, ans_btn,
        output logged_in, locked, rng_val, ans_val, sum_val, match, miss,
        output score, round_num, time_left, game_over
`ifdef STREAK_BONUS_EN
        , output streak
`endif
    );
endinterface

// File: rtl/second_timer.sv
// Seconds prescaler plus a loadable 7-bit down-counter that stops at zero.
module second_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int START         = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       enable,
    output logic [6:0] value,
    output logic       zero
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            value <= '0;
        end else if (load) begin
            presc <= '0;
            value <= 7'(START);
        end else if (enable) begin
            if (presc == LAST) begin
                presc <= '0;
                if (value != 7'd0) value <= value - 7'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign zero = (value == 7'd0);
endmodule

// File: rtl/binary_game_engine.sv
// Multi-round "complement the random number" game: login, countdown, scoring, lockout.
// Optional STREAK_BONUS_EN: third and later consecutive matches score 2.
module binary_game_engine
    import binary_game_pkg::*;
#(
    parameter int           W             = 4,
    parameter int           ROUNDS        = 8,
    parameter int           ROUND_SECS    = 9,
    parameter int           TICKS_PER_SEC = 50_000_000,
    parameter logic [W-1:0] PASSWORD      = W'(10),
    parameter int           MAX_TRIES     = 3,
    parameter int           SEED          = 1
) (
    input logic                 clk,
    input logic                 rst,
    binary_game_engine_if.slave bus
);
    localparam logic [7:0]   TAP_MASK   = lfsr_taps(W);
    localparam logic [W-1:0] TAPS       = TAP_MASK[W-1:0];
    localparam logic [W:0]   TARGET     = {1'b0, {W{1'b1}}};
    localparam logic [3:0]   LAST_ROUND = 4'(ROUNDS);
    localparam logic [3:0]   LAST_TRY   = 4'(MAX_TRIES - 1);

    game_state_t  state, state_n;
    logic [W-1:0] lfsr;
    logic [3:0]   tries;
    logic [6:0]   secs;
    logic         secs_zero;
    logic         pw_ok;
    logic [W:0]   sum_n;
    logic         hit;
    logic [3:0]   bonus;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    assign pw_ok = (bus.pw_in == PASSWORD);
    assign sum_n = {1'b0, bus.ans_val} + {1'b0, bus.rng_val};
    // A carry out means the sum overshot all-ones, so it is never a match
    assign hit   = (sum_n == TARGET);

    second_timer #(.TICKS_PER_SEC(TICKS_PER_SEC), .START(ROUND_SECS)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state == GEN),
        .enable (state == WAIT),
        .value  (secs),
        .zero   (secs_zero)
    );
    assign bus.time_left = secs;

    always_ff @(posedge clk) begin
        if (rst) state <= LOGIN;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LOGIN:   if (bus.pw_btn) begin
                         if (pw_ok)                  state_n = IDLE;
                         else if (tries == LAST_TRY) state_n = LOCKOUT;
                     end
            LOCKOUT: state_n = LOCKOUT;
            IDLE:    if (bus.pw_btn)         state_n = LOGIN;
                     else if (bus.start_btn) state_n = GEN;
            GEN:     state_n = WAIT;
            WAIT:    if (bus.ans_btn)        state_n = CHECK;
                     else if (secs_zero)     state_n = NEXT;
            CHECK:   state_n = NEXT;
            NEXT:    if (bus.round_num == LAST_ROUND) state_n = DONE;
                     else if (bus.start_btn)          state_n = GEN;
            DONE:    if (bus.pw_btn)         state_n = LOGIN;
                     else if (bus.start_btn) state_n = IDLE;
            default: state_n = LOGIN;
        endcase
    end

`ifdef STREAK_BONUS_EN
    logic [1:0] streak_q;

    always_ff @(posedge clk) begin
        if (rst)
            streak_q <= '0;
        else if (state == GEN && bus.round_num == 4'd1)
            streak_q <= '0;
        else if (state == CHECK)
            streak_q <= hit ? ((streak_q == 2'd3) ? streak_q : streak_q + 2'd1) : 2'd0;
        else if (state == WAIT && !bus.ans_btn && secs_zero)
            streak_q <= '0;
    end

    assign bus.streak = streak_q;
    assign bonus      = (streak_q >= 2'd2) ? 4'd2 : 4'd1;
`else
    assign bonus = 4'd1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr          <= W'(SEED);
            tries         <= '0;
            bus.logged_in <= 1'b0;
            bus.locked    <= 1'b0;
            bus.game_over <= 1'b0;
            bus.rng_val   <= '0;
            bus.ans_val   <= '0;
            bus.sum_val   <= '0;
            bus.match     <= 1'b0;
            bus.miss      <= 1'b0;
            bus.score     <= '0;
            bus.round_num <= '0;
        end else begin
            bus.match <= 1'b0;
            bus.miss  <= 1'b0;
            // Free-running so the drawn value depends on player timing
            if (state != LOCKOUT) lfsr <= lfsr_step(lfsr);
            bus.logged_in <= state_n inside {IDLE, GEN, WAIT, CHECK, NEXT, DONE};
            bus.locked    <= (state_n == LOCKOUT);
            bus.game_over <= (state_n == DONE);
            case (state)
                LOGIN: if (bus.pw_btn) tries <= pw_ok ? 4'd0 : tries + 4'd1;
                IDLE:  if (state_n == GEN) begin
                           bus.score     <= '0;
                           bus.round_num <= 4'd1;
                       end
                GEN:   bus.rng_val <= lfsr;
                WAIT:  if (bus.ans_btn)   bus.ans_val <= bus.ans_in;
                       else if (secs_zero) bus.miss   <= 1'b1;
                CHECK: begin
                           bus.sum_val <= sum_n;
                           if (hit) begin
                               bus.match <= 1'b1;
                               bus.score <= sat_add(bus.score, bonus);
                           end else begin
                               bus.miss <= 1'b1;
                           end
                       end
                NEXT:  if (state_n == GEN) bus.round_num <= bus.round_num + 4'd1;
                DONE:  if (state_n != DONE) bus.round_num <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/binary_game_engine.md
Name: binary_game_engine

Overview:
- Parametrised successor to the fixed 4-bit single-shot game top: a multi-round "complement the random number" game engine with login, per-round countdown, scoring and lockout.
- Sits between the button shapers, which deliver one-cycle pulses, and the 7-segment decoders, which consume `rng_val`, `sum_val`, `score` and `time_left`.
- Each round: an LFSR produces R. The player enters P. The round is a match when P + R == 2^W - 1 (all ones).

Parameters:
- W, 4: operand width in bits. Legal range 3..8.
- ROUNDS, 8: rounds per game. Legal range 1..15.
- ROUND_SECS, 9: countdown start value per round. Legal range 1..99.
- TICKS_PER_SEC, 50_000_000: clk cycles per second tick.
- PASSWORD, 4'hA: W-bit login code.
- MAX_TRIES, 3: wrong passwords tolerated before hard lock.
- SEED, 1: non-zero LFSR seed.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pw_in  in  W  password switches
- pw_btn  in  1  password-enter pulse (one cycle)
- start_btn  in  1  start/next-round pulse
- ans_in  in  W  player answer switches
- ans_btn  in  1  answer-submit pulse
- logged_in  out  1  high while session is authenticated
- locked  out  1  high after MAX_TRIES failures; cleared only by rst
- rng_val  out  W  current round's R
- ans_val  out  W  latched P
- sum_val  out  W+1  P + R, zero-extended, carry kept
- match  out  1  one-cycle pulse on a correct answer
- miss  out  1  one-cycle pulse on a wrong answer or timeout
- score  out  4  correct-answer count, saturating at 15
- round_num  out  4  current round, 1-based; 0 when idle
- time_left  out  7  seconds remaining in the round
- game_over  out  1  high in DONE

Behaviour:
- Reset values:
  - All outputs 0.
  - LFSR = SEED.
  - try counter = 0.
  - Tick prescaler = 0.
  - State = LOGIN.
- Clocking: single clock domain. All registered outputs change on the clk edge after the triggering pulse (one-cycle latency).
- LFSR: W-bit maximal-length Galois LFSR. It free-runs every cycle in every state except LOCKOUT, so R depends on player timing. R is never 0; that is acceptable.
- State machine:
  - LOGIN:
    - pw_btn with pw_in == PASSWORD → IDLE, `logged_in` = 1, tries cleared.
    - pw_btn with a wrong code increments tries. When tries reaches MAX_TRIES → LOCKOUT.
  - LOCKOUT: `locked` = 1. Ignores every input. Only rst exits.
  - IDLE:
    - start_btn → GEN; `score` = 0, `round_num` = 1.
    - pw_btn → LOGIN (logout), `logged_in` = 0.
  - GEN (one cycle): `rng_val` ← LFSR; `time_left` ← ROUND_SECS; prescaler cleared → WAIT.
  - WAIT:
    - Prescaler counts to TICKS_PER_SEC-1 and wraps. On each wrap `time_left` decrements.
    - ans_btn → `ans_val` ← ans_in → CHECK.
    - `time_left` reaching 0 with no answer → `miss` pulse → NEXT.
    - If ans_btn arrives on the same cycle as the final decrement, the answer wins.
  - CHECK (one cycle):
    - `sum_val` = ans_val + rng_val in W+1 bits.
    - Match iff sum_val == {1'b0, all ones}, i.e. 2^W - 1. Note 2^W - 1 + carry is a miss; the carry bit must be zero.
    - Match → `match` pulse, `score` += 1 (saturating). Miss → `miss` pulse. Then → NEXT.
  - NEXT:
    - round_num == ROUNDS → DONE.
    - Otherwise wait for start_btn; then `round_num` += 1 → GEN.
  - DONE:
    - `game_over` = 1; `score` and `round_num` are held.
    - start_btn → IDLE and clears `game_over`.
    - pw_btn → LOGIN.
- Input filtering: pulses that are irrelevant to the current state are ignored. This covers start_btn in WAIT and ans_btn outside WAIT.
- Simultaneous pulses: if pw_btn and start_btn arrive in the same cycle in IDLE or DONE, pw_btn (logout) has priority.
- Reset mid-game: returns to LOGIN with all state cleared, including `logged_in`. `locked` is cleared as well.

Optional Feature:
- Macro: `STREAK_BONUS_EN`.
- With the macro defined:
  - A 2-bit streak counter tracks consecutive matches.
  - The third and every later consecutive match adds 2 to `score` instead of 1, still saturating at 15.
  - Any miss or timeout clears the streak. GEN of round 1 clears it too.
  - An extra output `streak` (2 bits) exposes the counter.
- Without the macro: no streak logic, no `streak` port, and every match adds exactly 1.

Decomposition:
- Shared package `binary_game_pkg`:
  - State enum (LOGIN, LOCKOUT, IDLE, GEN, WAIT, CHECK, NEXT, DONE).
  - LFSR tap constants for W = 3..8.
  - Score saturation limit constant.
- Sub-module `second_timer`: prescaler plus loadable 7-bit BCD-agnostic down-counter.
  - Inputs: load, enable.
  - Outputs: value, zero flag.
  - Reused as the successor of the existing digit timer.

Test Plan:
- Login: rst, then pw_in = 4'h3 with pw_btn three times → `locked` = 1 after the third pulse. Further pw_btn with 4'hA → `locked` stays 1. rst → state LOGIN, `locked` = 0.
- Correct round: login with 4'hA, start_btn, read rng_val = R, ans_in = ~R, ans_btn → next cycle `sum_val` = 5'h0F, `match` pulses once, `score` = 1, `round_num` = 1.
- Wrong answer: rng_val = 4'h6, ans_in = 4'hA, ans_btn → `sum_val` = 5'h10, `miss` pulses, `score` unchanged.
- Timeout: TICKS_PER_SEC = 4, ROUND_SECS = 2, no answer.
  - `time_left` goes 2→1→0 at 4-cycle spacing, then `miss` pulses.
  - Repeat with ans_btn on the final-tick cycle → the answer is evaluated.
- Full game: ROUNDS = 3, all correct → `game_over` = 1, `score` = 3. With `STREAK_BONUS_EN` → `score` = 4.
- Mid-game reset: assert rst during WAIT of round 2 → next cycle all outputs 0, `logged_in` = 0, state LOGIN.
